// File: rtl/patch_reducer_scheduler.sv
// Binds incoming patches to free PatchReducer instances and drains finished patch sums,
// one 64-bit message at a time, toward the fpga_msg FIFO, recycling each reducer on transfer.
module patch_reducer_scheduler #(
    parameter int N_PATCH_REDUCER = 4,
    parameter int PATCH_ID_SIZE   = 17,
    parameter int PATCH_SUM_SIZE  = 34,
    parameter int RID_SIZE        = 2
) (
    input  logic                                      dram_clk,
    input  logic                                      reset,
    input  logic                                      alloc_req,
    input  logic [PATCH_ID_SIZE-1:0]                  alloc_patch_id,
    output logic                                      alloc_gnt,
    output logic [RID_SIZE-1:0]                       alloc_rid,
    output logic [N_PATCH_REDUCER-1:0]                patch_init,
    input  logic [N_PATCH_REDUCER-1:0]                patch_sum_rdy,
    input  logic [N_PATCH_REDUCER*PATCH_SUM_SIZE-1:0] patch_sum,
    output logic [N_PATCH_REDUCER-1:0]                patch_sum_ack,
    input  logic                                      fpga_msg_full,
    output logic                                      fpga_msg_valid,
    output logic [63:0]                               fpga_msg,
    output logic [RID_SIZE:0]                         busy_count,
    output logic                                      error
);

    localparam int BW  = RID_SIZE + 1;
    // Zero gap between the patch id field and the sum; id + sum must fit in 62 bits.
    localparam int PAD = 62 - PATCH_ID_SIZE - PATCH_SUM_SIZE;

    typedef enum logic {
        S_IDLE,
        S_EMIT
    } drain_state_e;

    drain_state_e                   state_q, state_d;
    logic [N_PATCH_REDUCER-1:0]     free_q, free_d;
    logic [PATCH_ID_SIZE-1:0]       pid_q [N_PATCH_REDUCER];
    logic [RID_SIZE-1:0]            rr_ptr_q, rr_ptr_d;
    logic [RID_SIZE-1:0]            sel_q, sel_d;
    logic                           gnt_q, gnt_d;
    logic [RID_SIZE-1:0]            rid_q, rid_d;
    logic [N_PATCH_REDUCER-1:0]     init_q, init_d;
    logic [N_PATCH_REDUCER-1:0]     ack_q, ack_d;
    logic [63:0]                    msg_q, msg_d;
    logic [BW-1:0]                  busy_q, busy_d;
    logic                           err_q, err_d;
    logic [PATCH_ID_SIZE-1:0]       gnt_id_q, gnt_id_d;

    logic                           alloc_found;
    logic [RID_SIZE-1:0]            alloc_idx;
    logic                           alloc_fire;
    logic [N_PATCH_REDUCER-1:0]     cand;
    logic                           win_found;
    logic [RID_SIZE-1:0]            win_idx;
    logic                           transfer;

    // Lowest-index free reducer, taken from the registered free mask only.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch so no latch is inferred.
        alloc_found = 1'b0;
        alloc_idx   = '0;
        for (int i = N_PATCH_REDUCER - 1; i >= 0; i--) begin
            if (free_q[i]) begin
                alloc_found = 1'b1;
                alloc_idx   = RID_SIZE'(i);
            end
        end
    end

    assign alloc_fire = alloc_req && alloc_found && !gnt_q;

    // Round-robin pick starting just after the last winner; the last winner has lowest priority.
    always_comb begin
        cand      = patch_sum_rdy & ~free_q;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = N_PATCH_REDUCER; k >= 1; k--) begin
            if (cand[(int'(rr_ptr_q) + k) % N_PATCH_REDUCER]) begin
                win_found = 1'b1;
                win_idx   = RID_SIZE'((int'(rr_ptr_q) + k) % N_PATCH_REDUCER);
            end
        end
    end

    assign transfer = (state_q == S_EMIT) && !fpga_msg_full;

    always_comb begin
        state_d  = state_q;
        free_d   = free_q;
        rr_ptr_d = rr_ptr_q;
        sel_d    = sel_q;
        msg_d    = msg_q;
        ack_d    = '0;
        gnt_d    = alloc_fire;
        rid_d    = alloc_fire ? alloc_idx : '0;
        init_d   = '0;
        gnt_id_d = gnt_id_q;

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    msg_d = {2'b01, pid_q[win_idx], {PAD{1'b0}},
                             patch_sum[int'(win_idx)*PATCH_SUM_SIZE +: PATCH_SUM_SIZE]};
                    ack_d[win_idx] = 1'b1;
                    rr_ptr_d       = win_idx;
                    sel_d          = win_idx;
                    state_d        = S_EMIT;
                end
            end
            S_EMIT: begin
                if (transfer) begin
                    free_d[sel_q] = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (alloc_fire) begin
            free_d[alloc_idx]  = 1'b0;
            init_d[alloc_idx]  = 1'b1;
            gnt_id_d           = alloc_patch_id;
        end

        busy_d = busy_q + BW'(alloc_fire) - BW'(transfer);

        // Sum reported by an unallocated reducer, or the requester changed its id mid-grant.
        err_d = err_q
              | (|(patch_sum_rdy & free_q))
              | (alloc_req && gnt_q && (alloc_patch_id != gnt_id_q));
    end

    always_ff @(posedge dram_clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            free_q   <= '1;
            rr_ptr_q <= RID_SIZE'(N_PATCH_REDUCER - 1);
            sel_q    <= '0;
            gnt_q    <= 1'b0;
            rid_q    <= '0;
            init_q   <= '0;
            ack_q    <= '0;
            msg_q    <= '0;
            busy_q   <= '0;
            err_q    <= 1'b0;
            gnt_id_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            free_q   <= free_d;
            rr_ptr_q <= rr_ptr_d;
            sel_q    <= sel_d;
            gnt_q    <= gnt_d;
            rid_q    <= rid_d;
            init_q   <= init_d;
            ack_q    <= ack_d;
            msg_q    <= msg_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            gnt_id_q <= gnt_id_d;
        end
    end

    // NOTE: the patch id table is small and must read as cleared after reset, so it is reset like any register.
    always_ff @(posedge dram_clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_PATCH_REDUCER; i++) begin
                pid_q[i] <= '0;
            end
        end else if (alloc_fire) begin
            pid_q[alloc_idx] <= alloc_patch_id;
        end
    end

    assign alloc_gnt      = gnt_q;
    assign alloc_rid      = rid_q;
    assign patch_init     = init_q;
    assign patch_sum_ack  = ack_q;
    assign fpga_msg_valid = transfer;
    assign fpga_msg       = msg_q;
    assign busy_count     = busy_q;
    assign error          = err_q;

endmodule

// File: tb/tb_patch_reducer_scheduler.sv
// Directed bench for patch_reducer_scheduler: allocation, round-robin drain, back-pressure,
// protocol error and mid-operation reset, with expected messages kept in a scoreboard queue.
module tb_patch_reducer_scheduler;

    localparam int N   = 4;
    localparam int PID = 17;
    localparam int S   = 34;
    localparam int RID = 2;

    logic              dram_clk = 1'b0;
    logic              reset    = 1'b0;
    logic              alloc_req = 1'b0;
    logic [PID-1:0]    alloc_patch_id = '0;
    logic              alloc_gnt;
    logic [RID-1:0]    alloc_rid;
    logic [N-1:0]      patch_init;
    logic [N-1:0]      patch_sum_rdy = '0;
    logic [N*S-1:0]    patch_sum = '0;
    logic [N-1:0]      patch_sum_ack;
    logic              fpga_msg_full = 1'b0;
    logic              fpga_msg_valid;
    logic [63:0]       fpga_msg;
    logic [RID:0]      busy_count;
    logic              error;

    logic [63:0]       exp_q [$];
    logic [PID-1:0]    id_tbl [N];
    int                vectors     = 0;
    int                miscompares = 0;

    patch_reducer_scheduler #(
        .N_PATCH_REDUCER(N),
        .PATCH_ID_SIZE  (PID),
        .PATCH_SUM_SIZE (S),
        .RID_SIZE       (RID)
    ) dut (
        .dram_clk      (dram_clk),
        .reset         (reset),
        .alloc_req     (alloc_req),
        .alloc_patch_id(alloc_patch_id),
        .alloc_gnt     (alloc_gnt),
        .alloc_rid     (alloc_rid),
        .patch_init    (patch_init),
        .patch_sum_rdy (patch_sum_rdy),
        .patch_sum     (patch_sum),
        .patch_sum_ack (patch_sum_ack),
        .fpga_msg_full (fpga_msg_full),
        .fpga_msg_valid(fpga_msg_valid),
        .fpga_msg      (fpga_msg),
        .busy_count    (busy_count),
        .error         (error)
    );

    always #5 dram_clk = ~dram_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk_msg(input logic [PID-1:0] id, input logic [S-1:0] sum);
        return {2'b01, id, 11'b0, sum};
    endfunction

    // One clock; a reducer drops its ready flag once it sees its ack.
    task automatic tick();
        @(posedge dram_clk);
        #1;
        patch_sum_rdy = patch_sum_rdy & ~patch_sum_ack;
        #1;
    endtask

    task automatic do_reset(input string tag);
        reset          = 1'b0;
        alloc_req      = 1'b0;
        patch_sum_rdy  = '0;
        fpga_msg_full  = 1'b0;
        exp_q.delete();
        #3;
        check({tag, "_gnt"},   alloc_gnt, 0);
        check({tag, "_rid"},   alloc_rid, 0);
        check({tag, "_init"},  patch_init, 0);
        check({tag, "_ack"},   patch_sum_ack, 0);
        check({tag, "_valid"}, fpga_msg_valid, 0);
        check({tag, "_msg"},   fpga_msg, 0);
        check({tag, "_busy"},  busy_count, 0);
        check({tag, "_err"},   error, 0);
        @(negedge dram_clk);
        reset = 1'b1;
    endtask

    task automatic alloc(input string tag, input logic [PID-1:0] id, input int exp_rid);
        bit found = 0;
        logic [N-1:0] onehot = '0;
        onehot[exp_rid] = 1'b1;
        alloc_patch_id = id;
        alloc_req      = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (alloc_gnt) found = 1;
        end
        check({tag, "_gnt_seen"}, found, 1);
        check({tag, "_rid"},  alloc_rid, exp_rid);
        check({tag, "_init"}, patch_init, onehot);
        alloc_req = 1'b0;
        id_tbl[exp_rid] = id;
        tick();
    endtask

    task automatic raise(input int idx, input logic [S-1:0] sum);
        patch_sum[idx*S +: S] = sum;
        patch_sum_rdy[idx]    = 1'b1;
        exp_q.push_back(mk_msg(id_tbl[idx], sum));
    endtask

    // Wait for a valid message, compare it with the scoreboard head, then take the transfer edge.
    task automatic wait_msg(input string tag, input int budget);
        bit found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            tick();
            if (fpga_msg_valid) found = 1;
        end
        check({tag, "_valid_seen"}, found, 1);
        if (found && exp_q.size() > 0) check({tag, "_msg"}, fpga_msg, exp_q.pop_front());
        tick();
    endtask

    initial begin
        for (int i = 0; i < N; i++) id_tbl[i] = '0;

        // Reset state, then a single allocation.
        do_reset("rst0");
        alloc_patch_id = 17'd100;
        alloc_req      = 1'b1;
        tick();
        check("t1_gnt",  alloc_gnt, 1);
        check("t1_rid",  alloc_rid, 0);
        check("t1_init", patch_init, 4'b0001);
        check("t1_busy", busy_count, 1);
        alloc_req = 1'b0;
        tick();
        check("t1_gnt_drop", alloc_gnt, 0);

        // Fill the pool, stall a fifth request, free reducer 2 and watch it regranted.
        do_reset("rst1");
        alloc("t2_a1", 17'd1, 0);
        alloc("t2_a2", 17'd2, 1);
        alloc("t2_a3", 17'd3, 2);
        alloc("t2_a4", 17'd4, 3);
        check("t2_busy4", busy_count, 4);
        alloc_patch_id = 17'd5;
        alloc_req      = 1'b1;
        tick(); tick(); tick();
        check("t2_stall", alloc_gnt, 0);
        raise(2, 34'h0_0000_0123);
        tick();
        check("t2_ack",   patch_sum_ack, 4'b0100);
        check("t2_valid", fpga_msg_valid, 1);
        check("t2_msg",   fpga_msg, exp_q.pop_front());
        tick();
        check("t2_nogrant_at_free", alloc_gnt, 0);
        check("t2_busy3", busy_count, 3);
        tick();
        check("t2_regrant", alloc_gnt, 1);
        check("t2_rid2",    alloc_rid, 2);
        check("t2_busy4b",  busy_count, 4);
        alloc_req = 1'b0;
        id_tbl[2] = 17'd5;
        tick();

        // Round robin from rr_ptr=0 with reducers 1 and 3 ready together.
        do_reset("rst2");
        alloc("t3_a0", 17'd10, 0);
        alloc("t3_a1", 17'd11, 1);
        alloc("t3_a2", 17'd12, 2);
        alloc("t3_a3", 17'd13, 3);
        raise(0, 34'h0_0000_0055);
        wait_msg("t3_r0", 8);
        raise(1, 34'h3_0000_0001);
        raise(3, 34'h2_ABCD_0123);
        wait_msg("t3_first_r1", 8);
        wait_msg("t3_second_r3", 8);
        check("t3_busy", busy_count, 1);

        // Back-pressure in EMIT: nothing moves until full drops, then exactly one pulse.
        fpga_msg_full = 1'b1;
        raise(2, 34'h0_DEAD_BEEF);
        tick();
        check("t4_ack", patch_sum_ack, 4'b0100);
        for (int c = 0; c < 10; c++) begin
            check("t4_valid_held", fpga_msg_valid, 0);
            check("t4_msg_stable", fpga_msg, exp_q[0]);
            check("t4_busy_held",  busy_count, 1);
            tick();
        end
        fpga_msg_full = 1'b0;
        #1;
        check("t4_valid", fpga_msg_valid, 1);
        check("t4_msg",   fpga_msg, exp_q.pop_front());
        tick();
        check("t4_single_pulse", fpga_msg_valid, 0);
        check("t4_busy0",        busy_count, 0);
        tick();
        check("t4_still_idle",   fpga_msg_valid, 0);

        // Ready from a free reducer: sticky error, no ack, no message.
        patch_sum_rdy[3] = 1'b1;
        tick();
        check("t5_err",    error, 1);
        check("t5_no_ack", patch_sum_ack, 0);
        tick();
        check("t5_no_msg", fpga_msg_valid, 0);
        patch_sum_rdy = '0;
        tick(); tick();
        check("t5_sticky", error, 1);

        // Reset while a message is in EMIT.
        do_reset("rst3");
        alloc("t6_a0", 17'd20, 0);
        alloc("t6_a1", 17'd21, 1);
        alloc("t6_a2", 17'd22, 2);
        raise(1, 34'h0_0000_0077);
        tick();
        check("t6_in_emit", fpga_msg_valid, 1);
        #1;
        reset = 1'b0;
        #1;
        check("t6_gnt",   alloc_gnt, 0);
        check("t6_init",  patch_init, 0);
        check("t6_ack",   patch_sum_ack, 0);
        check("t6_valid", fpga_msg_valid, 0);
        check("t6_msg",   fpga_msg, 0);
        check("t6_busy",  busy_count, 0);
        check("t6_err",   error, 0);
        exp_q.delete();
        patch_sum_rdy = '0;
        @(negedge dram_clk);
        reset = 1'b1;
        alloc("t6_after", 17'd30, 0);
        check("t6_busy1", busy_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
